sdram_arbiter: RTL and testbench

//  Shares the single-request sdram controller port between video, CPU, DMA and blitter.

---
 rtl/sdram_arb_pkg.sv | 42 ++++
 rtl/sdram_arb_if.sv | 64 ++++++
 rtl/sdram_arb_slot_timer.sv | 54 +++++
 rtl/sdram_arbiter.sv | 166 ++++++++++++++++
 tb/tb_sdram_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the slot-synchronous SDRAM port arbiter.
// Port IDs, slot geometry and the registered controller command record.
package sdram_arb_pkg;

  typedef enum logic [2:0] {
    P_NONE  = 3'd0,
    P_VIDEO = 3'd1,
    P_CPU   = 3'd2,
    P_DMA   = 3'd3,
    P_BLIT  = 3'd4
  } port_id_e;

  localparam int unsigned SLOT_LEN = 12;
  localparam int unsigned PhW      = 4;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [1:0]  ds;
    logic [23:0] addr;
    logic [15:0] din;
  } mem_cmd_t;

  function automatic logic [PhW-1:0] ph_next(input logic [PhW-1:0] ph);
    return (ph == PhW'(SLOT_LEN - 1)) ? '0 : ph + PhW'(1);
  endfunction

  // Builds the controller command for a 16-bit client grant.
  function automatic mem_cmd_t client_cmd(input logic        we,
                                          input logic [1:0]  ds,
                                          input logic [23:0] addr,
                                          input logic [15:0] din);
    mem_cmd_t cmd;
    cmd.req  = 1'b1;
    cmd.we   = we;
    cmd.ds   = ds;
    cmd.addr = addr;
    cmd.din  = din;
    return cmd;
  endfunction

endpackage

// File: rtl/sdram_arb_if.sv
// Bundle of requester handshakes plus the SDRAM controller command/data port.
// master = arbiter side, slave = requesters and controller side.
interface sdram_arb_if;

  logic        video_req;
  logic [23:0] video_addr;
  logic        video_ack;
  logic [63:0] video_data;

  logic        cpu_req;
  logic        cpu_we;
  logic [1:0]  cpu_ds;
  logic [23:0] cpu_addr;
  logic [15:0] cpu_din;
  logic        cpu_ack;
  logic [15:0] cpu_dout;

  logic        dma_req;
  logic        dma_we;
  logic [1:0]  dma_ds;
  logic [23:0] dma_addr;
  logic [15:0] dma_din;
  logic        dma_ack;
  logic [15:0] dma_dout;

  logic        blit_req;
  logic        blit_we;
  logic [1:0]  blit_ds;
  logic [23:0] blit_addr;
  logic [15:0] blit_din;
  logic        blit_ack;
  logic [15:0] blit_dout;

  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_ds;
  logic [23:0] mem_addr;
  logic [15:0] mem_din;
  logic [15:0] mem_dout;
  logic [63:0] mem_dout64;

  modport master (
    input  video_req, video_addr,
    input  cpu_req, cpu_we, cpu_ds, cpu_addr, cpu_din,
    input  dma_req, dma_we, dma_ds, dma_addr, dma_din,
    input  blit_req, blit_we, blit_ds, blit_addr, blit_din,
    input  mem_dout, mem_dout64,
    output video_ack, video_data, cpu_ack, cpu_dout,
    output dma_ack, dma_dout, blit_ack, blit_dout,
    output mem_req, mem_we, mem_ds, mem_addr, mem_din
  );

  modport slave (
    output video_req, video_addr,
    output cpu_req, cpu_we, cpu_ds, cpu_addr, cpu_din,
    output dma_req, dma_we, dma_ds, dma_addr, dma_din,
    output blit_req, blit_we, blit_ds, blit_addr, blit_din,
    output mem_dout, mem_dout64,
    input  video_ack, video_data, cpu_ack, cpu_dout,
    input  dma_ack, dma_dout, blit_ack, blit_dout,
    input  mem_req, mem_we, mem_ds, mem_addr, mem_din
  );

endinterface

// File: rtl/sdram_arb_slot_timer.sv
// Slot edge detect, phase counter and refresh-starvation guard.
// force_idle rises after REFRESH_SLOTS back-to-back granted slots.
module sdram_arb_slot_timer
  import sdram_arb_pkg::*;
#(
  parameter int unsigned REFRESH_SLOTS = 60
) (
  input  logic clk_96,
  input  logic init,
  input  logic clk_8_en,
  input  logic slot_grant,
  output logic slot_edge,
  output logic force_idle
);

  localparam int unsigned    CntW   = $clog2(REFRESH_SLOTS + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(REFRESH_SLOTS);

  logic            en_q, en_d;
  logic [PhW-1:0]  ph_q, ph_d;
  logic [CntW-1:0] busy_q, busy_d;

  assign slot_edge  = clk_8_en & ~en_q;
  assign force_idle = (busy_q == CntMax);

  always_comb begin
    en_d   = clk_8_en;
    ph_d   = slot_edge ? '0 : ph_next(ph_q);
    busy_d = busy_q;
    if (slot_edge) begin
      // The forced slot itself is idle, so the run length restarts from zero.
      if (force_idle) begin
        busy_d = '0;
      end else if (slot_grant) begin
        busy_d = busy_q + CntW'(1);
      end else begin
        busy_d = '0;
      end
    end
  end

  always_ff @(posedge clk_96) begin
    if (init) begin
      en_q   <= 1'b0;
      ph_q   <= '0;
      busy_q <= '0;
    end else begin
      en_q   <= en_d;
      ph_q   <= ph_d;
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Grants one requester per 8MHz slot onto the single SDRAM controller port and
// returns the previous slot's read data with a one-cycle ack on the next slot edge.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int unsigned REFRESH_SLOTS = 60
) (
  input  logic        clk_96,
  input  logic        init,
  input  logic        clk_8_en,
  sdram_arb_if.master bus
);

  logic     slot_edge;
  logic     force_idle;
  logic     slot_grant;
  port_id_e winner;
  logic     cand_video, cand_cpu, cand_dma, cand_blit;

  port_id_e    inflight_q, inflight_d;
  port_id_e    rr_q, rr_d;
  mem_cmd_t    mem_q, mem_d;
  logic        video_ack_q, video_ack_d;
  logic        cpu_ack_q, cpu_ack_d;
  logic        dma_ack_q, dma_ack_d;
  logic        blit_ack_q, blit_ack_d;
  logic [63:0] video_data_q, video_data_d;
  logic [15:0] cpu_dout_q, cpu_dout_d;
  logic [15:0] dma_dout_q, dma_dout_d;
  logic [15:0] blit_dout_q, blit_dout_d;

  sdram_arb_slot_timer #(
    .REFRESH_SLOTS(REFRESH_SLOTS)
  ) u_slot_timer (
    .clk_96    (clk_96),
    .init      (init),
    .clk_8_en  (clk_8_en),
    .slot_grant(slot_grant),
    .slot_edge (slot_edge),
    .force_idle(force_idle)
  );

  // The port completing this slot is excluded so its stale req cannot win again.
  always_comb begin
    cand_video = bus.video_req && (inflight_q != P_VIDEO);
    cand_cpu   = bus.cpu_req   && (inflight_q != P_CPU);
    cand_dma   = bus.dma_req   && (inflight_q != P_DMA);
    cand_blit  = bus.blit_req  && (inflight_q != P_BLIT);
    winner     = P_NONE;
    if (!force_idle) begin
      if (cand_video) begin
        winner = P_VIDEO;
      end else if (cand_cpu) begin
        winner = P_CPU;
      end else if (cand_dma && cand_blit) begin
        winner = rr_q;
      end else if (cand_dma) begin
        winner = P_DMA;
      end else if (cand_blit) begin
        winner = P_BLIT;
      end
    end
  end

  assign slot_grant = (winner != P_NONE);

  always_comb begin
    inflight_d   = inflight_q;
    rr_d         = rr_q;
    mem_d        = mem_q;
    video_ack_d  = 1'b0;
    cpu_ack_d    = 1'b0;
    dma_ack_d    = 1'b0;
    blit_ack_d   = 1'b0;
    video_data_d = video_data_q;
    cpu_dout_d   = cpu_dout_q;
    dma_dout_d   = dma_dout_q;
    blit_dout_d  = blit_dout_q;

    if (slot_edge) begin
      case (inflight_q)
        P_VIDEO: begin
          video_ack_d  = 1'b1;
          video_data_d = bus.mem_dout64;
        end
        P_CPU: begin
          cpu_ack_d  = 1'b1;
          cpu_dout_d = bus.mem_dout;
        end
        P_DMA: begin
          dma_ack_d  = 1'b1;
          dma_dout_d = bus.mem_dout;
        end
        P_BLIT: begin
          blit_ack_d  = 1'b1;
          blit_dout_d = bus.mem_dout;
        end
        default: ;
      endcase

      inflight_d = winner;
      // Idle slots only drop req; the rest of the command stays as last driven.
      mem_d.req  = slot_grant;
      case (winner)
        P_VIDEO: begin
          mem_d.we   = 1'b0;
          mem_d.ds   = 2'b11;
          mem_d.addr = bus.video_addr;
        end
        P_CPU:  mem_d = client_cmd(bus.cpu_we, bus.cpu_ds, bus.cpu_addr, bus.cpu_din);
        P_DMA: begin
          mem_d = client_cmd(bus.dma_we, bus.dma_ds, bus.dma_addr, bus.dma_din);
          rr_d  = P_BLIT;
        end
        P_BLIT: begin
          mem_d = client_cmd(bus.blit_we, bus.blit_ds, bus.blit_addr, bus.blit_din);
          rr_d  = P_DMA;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_96) begin
    if (init) begin
      inflight_q   <= P_NONE;
      rr_q         <= P_DMA;
      mem_q        <= '0;
      video_ack_q  <= 1'b0;
      cpu_ack_q    <= 1'b0;
      dma_ack_q    <= 1'b0;
      blit_ack_q   <= 1'b0;
      video_data_q <= '0;
      cpu_dout_q   <= '0;
      dma_dout_q   <= '0;
      blit_dout_q  <= '0;
    end else begin
      inflight_q   <= inflight_d;
      rr_q         <= rr_d;
      mem_q        <= mem_d;
      video_ack_q  <= video_ack_d;
      cpu_ack_q    <= cpu_ack_d;
      dma_ack_q    <= dma_ack_d;
      blit_ack_q   <= blit_ack_d;
      video_data_q <= video_data_d;
      cpu_dout_q   <= cpu_dout_d;
      dma_dout_q   <= dma_dout_d;
      blit_dout_q  <= blit_dout_d;
    end
  end

  assign bus.mem_req    = mem_q.req;
  assign bus.mem_we     = mem_q.we;
  assign bus.mem_ds     = mem_q.ds;
  assign bus.mem_addr   = mem_q.addr;
  assign bus.mem_din    = mem_q.din;
  assign bus.video_ack  = video_ack_q;
  assign bus.video_data = video_data_q;
  assign bus.cpu_ack    = cpu_ack_q;
  assign bus.cpu_dout   = cpu_dout_q;
  assign bus.dma_ack    = dma_ack_q;
  assign bus.dma_dout   = dma_dout_q;
  assign bus.blit_ack   = blit_ack_q;
  assign bus.blit_dout  = blit_dout_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Randomized bench for sdram_arbiter against a slot-history reference model.
// Requester index: 0 video, 1 cpu, 2 dma, 3 blit; -1 marks an idle slot.
module tb_sdram_arbiter;

  localparam int unsigned RS = 4;

  logic clk_96 = 1'b0;
  logic init;
  logic clk_8_en;

  always #5 clk_96 = ~clk_96;

  sdram_arb_if bus ();

  sdram_arbiter #(
    .REFRESH_SLOTS(RS)
  ) dut (
    .clk_96  (clk_96),
    .init    (init),
    .clk_8_en(clk_8_en),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Requester state. mode: 0 off, 1 held forever, 2 one-shot, 3 random traffic.
  int          mode  [4];
  logic        rq    [4];
  logic        rwe   [4];
  logic [1:0]  rds   [4];
  logic [23:0] raddr [4];
  logic [15:0] rdin  [4];

  // Reference model: list of slot winners since reset plus expected outputs.
  int          hist[$];
  logic        prev_en;
  logic        e_req, e_we;
  logic [1:0]  e_ds;
  logic [23:0] e_addr;
  logic [15:0] e_din;
  logic        e_ack  [4];
  logic [63:0] e_vdata;
  logic [15:0] e_dout [4];

  int   tb_ph;
  logic en_enable;
  int   cpu_ack_seen;

  function automatic int last_db_winner();
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] == 2 || hist[i] == 3) return hist[i];
    end
    return -1;
  endfunction

  task automatic model_reset();
    hist.delete();
    prev_en = 1'b0;
    e_req   = 1'b0;
    e_we    = 1'b0;
    e_ds    = '0;
    e_addr  = '0;
    e_din   = '0;
    e_vdata = '0;
    for (int p = 0; p < 4; p++) begin
      e_ack[p]  = 1'b0;
      e_dout[p] = '0;
    end
  endtask

  task automatic model_eval();
    int   prev, run, w;
    logic edge_now, d, b;
    if (init) begin
      model_reset();
      return;
    end
    edge_now = clk_8_en && !prev_en;
    prev_en  = clk_8_en;
    for (int p = 0; p < 4; p++) e_ack[p] = 1'b0;
    if (!edge_now) return;

    prev = (hist.size() > 0) ? hist[hist.size() - 1] : -1;
    if (prev == 0) begin
      e_ack[0] = 1'b1;
      e_vdata  = bus.mem_dout64;
    end else if (prev > 0) begin
      e_ack[prev]  = 1'b1;
      e_dout[prev] = bus.mem_dout;
    end

    run = 0;
    for (int i = hist.size() - 1; i >= 0 && hist[i] >= 0; i--) run++;

    w = -1;
    if (run < RS) begin
      d = rq[2] && prev != 2;
      b = rq[3] && prev != 3;
      if (rq[0] && prev != 0) w = 0;
      else if (rq[1] && prev != 1) w = 1;
      else if (d && b) w = (last_db_winner() == 2) ? 3 : 2;
      else if (d) w = 2;
      else if (b) w = 3;
    end
    hist.push_back(w);

    e_req = (w >= 0);
    if (w == 0) begin
      e_we   = 1'b0;
      e_ds   = 2'b11;
      e_addr = raddr[0];
    end else if (w > 0) begin
      e_we   = rwe[w];
      e_ds   = rds[w];
      e_addr = raddr[w];
      e_din  = rdin[w];
    end
  endtask

  task automatic drive();
    bus.video_req  = rq[0];
    bus.video_addr = raddr[0];
    bus.cpu_req    = rq[1];
    bus.cpu_we     = rwe[1];
    bus.cpu_ds     = rds[1];
    bus.cpu_addr   = raddr[1];
    bus.cpu_din    = rdin[1];
    bus.dma_req    = rq[2];
    bus.dma_we     = rwe[2];
    bus.dma_ds     = rds[2];
    bus.dma_addr   = raddr[2];
    bus.dma_din    = rdin[2];
    bus.blit_req   = rq[3];
    bus.blit_we    = rwe[3];
    bus.blit_ds    = rds[3];
    bus.blit_addr  = raddr[3];
    bus.blit_din   = rdin[3];
    bus.mem_dout   = 16'($urandom);
    bus.mem_dout64 = {$urandom, $urandom};
    clk_8_en       = en_enable && (tb_ph < 6);
  endtask

  task automatic compare();
    check_eq("mem_req", 64'(bus.mem_req), 64'(e_req));
    check_eq("mem_we", 64'(bus.mem_we), 64'(e_we));
    check_eq("mem_ds", 64'(bus.mem_ds), 64'(e_ds));
    check_eq("mem_addr", 64'(bus.mem_addr), 64'(e_addr));
    check_eq("mem_din", 64'(bus.mem_din), 64'(e_din));
    check_eq("video_ack", 64'(bus.video_ack), 64'(e_ack[0]));
    check_eq("cpu_ack", 64'(bus.cpu_ack), 64'(e_ack[1]));
    check_eq("dma_ack", 64'(bus.dma_ack), 64'(e_ack[2]));
    check_eq("blit_ack", 64'(bus.blit_ack), 64'(e_ack[3]));
    check_eq("video_data", bus.video_data, e_vdata);
    check_eq("cpu_dout", 64'(bus.cpu_dout), 64'(e_dout[1]));
    check_eq("dma_dout", 64'(bus.dma_dout), 64'(e_dout[2]));
    check_eq("blit_dout", 64'(bus.blit_dout), 64'(e_dout[3]));
  endtask

  task automatic rand_fields(input int p);
    rwe[p]   = 1'($urandom);
    rds[p]   = 2'($urandom);
    raddr[p] = 24'($urandom);
    rdin[p]  = 16'($urandom);
  endtask

  task automatic update_reqs();
    if (bus.cpu_ack) cpu_ack_seen++;
    for (int p = 0; p < 4; p++) begin
      if (e_ack[p] && mode[p] >= 2) rq[p] = 1'b0;
      case (mode[p])
        0: rq[p] = 1'b0;
        1: rq[p] = 1'b1;
        3: begin
          if (rq[p] && $urandom_range(0, 63) == 0) begin
            rq[p] = 1'b0;
          end else if (!rq[p] && $urandom_range(0, 3) == 0) begin
            rq[p] = 1'b1;
            rand_fields(p);
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic set_mode(input int p, input int m);
    mode[p] = m;
    rq[p]   = (m == 1 || m == 2);
  endtask

  task automatic step();
    drive();
    model_eval();
    @(posedge clk_96);
    #1;
    compare();
    tb_ph = (tb_ph + 1) % 12;
    update_reqs();
  endtask

  task automatic run_slots(input int n);
    repeat (n * 12) step();
  endtask

  task automatic all_off();
    for (int p = 0; p < 4; p++) set_mode(p, 0);
  endtask

  initial begin
    init         = 1'b1;
    tb_ph        = 0;
    en_enable    = 1'b1;
    cpu_ack_seen = 0;
    for (int p = 0; p < 4; p++) begin
      rwe[p]   = 1'b0;
      rds[p]   = '0;
      raddr[p] = '0;
      rdin[p]  = '0;
    end
    all_off();
    model_reset();
    repeat (3) step();
    init = 1'b0;

    // Single video reader.
    raddr[0] = 24'h010000;
    set_mode(0, 1);
    run_slots(3);
    all_off();
    run_slots(2);

    // Video, cpu and dma contending, then video withdrawn with blit added.
    for (int p = 0; p < 4; p++) rand_fields(p);
    set_mode(0, 1);
    set_mode(1, 1);
    set_mode(2, 1);
    run_slots(8);
    set_mode(0, 0);
    set_mode(3, 1);
    run_slots(8);
    all_off();
    run_slots(2);

    // dma/blit round robin.
    set_mode(2, 1);
    set_mode(3, 1);
    run_slots(8);
    all_off();
    run_slots(2);

    // One cpu write: exactly one ack.
    rwe[1]       = 1'b1;
    rds[1]       = 2'b01;
    rdin[1]      = 16'hBEEF;
    raddr[1]     = 24'h000123;
    cpu_ack_seen = 0;
    set_mode(1, 2);
    run_slots(4);
    check_eq("cpu_write_ack_count", 64'(cpu_ack_seen), 64'd1);

    // No slot edges: nothing granted or acked until the enable resumes.
    en_enable = 1'b0;
    rwe[1]    = 1'b0;
    set_mode(1, 2);
    repeat (40) step();
    en_enable = 1'b1;
    run_slots(3);

    // Reset while a cpu read is in flight.
    for (int i = 0; i < 12 && tb_ph != 0; i++) step();
    set_mode(1, 2);
    repeat (4) step();
    init = 1'b1;
    step();
    check_eq("init_mem_req", 64'(bus.mem_req), 64'd0);
    init         = 1'b0;
    cpu_ack_seen = 0;
    set_mode(1, 0);
    run_slots(3);
    check_eq("init_abandon_ack_count", 64'(cpu_ack_seen), 64'd0);
    set_mode(1, 2);
    run_slots(3);
    check_eq("post_init_cpu_ack_count", 64'(cpu_ack_seen), 64'd1);

    // Random traffic on all ports.
    for (int p = 0; p < 4; p++) set_mode(p, 3);
    run_slots(150);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
